tube_scan: RTL and testbench
============================

Name: tube_scan

Overview:
Time-multiplexed driver for a bank of 7-segment hex digits.
- Scans DIGITS digits round-robin, one digit enabled at a time, each held for CLK_DIV clocks.
- Per-digit decimal point and blanking.
- Display data is double-buffered: a host loads a new frame at any time, and it is committed only at a frame boundary, so there is no tearing.
- Sits between board-level display pins and any counter/status logic that wants to show hex values.

Parameters:
DIGITS, 8, number of digits scanned (1..16)
CLK_DIV, 50000, clocks each digit stays enabled (>=2)
SEG_ACTIVE_LOW, 1, 1 = segment lit by driving 0
DIG_ACTIVE_LOW, 1, 1 = digit enabled by driving 0

Ports:
clk  in  1  system clock
rst  in  1  reset
data  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3..4i) drives digit i
dp_in  in  DIGITS  bit i set = decimal point of digit i lit
blank_in  in  DIGITS  bit i set = digit i dark (all segments off)
load  in  1  single-cycle strobe; captures data/dp_in/blank_in into pending buffer
LED7S  out  8  segments; bit7 = dp, bits6..0 = g..a
dig  out  DIGITS  digit enables; bit i = digit i
frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0

Interface rule: one clock, clk; reset is synchronous and active-high, rst.

Behaviour:
- Prescaler:
  - Counts 0..CLK_DIV-1.
  - tick is asserted in the cycle the count equals CLK_DIV-1; the count returns to 0 on the next edge.
- Digit index:
  - Advances on tick.
  - Wraps from DIGITS-1 to 0 (wrap = tick AND index==DIGITS-1).
  - For DIGITS=1 the index stays 0 and every tick is a wrap.
- Pending buffer:
  - load captures data, dp_in and blank_in, and sets pending_valid.
  - A second load before commit overwrites the buffer; the last load wins.
- Commit:
  - On a wrap with pending_valid=1, active <= pending and pending_valid clears.
  - If load and wrap occur in the same cycle, the wrap commits the older pending contents (if valid). The new load is held and commits at the next wrap.
- Decode, active-low polarity (0..F): C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - dp lit clears bit7.
  - Blanked digit gives FF.
  - SEG_ACTIVE_LOW=0 inverts all 8 bits.
- dig:
  - One-hot on the current index, polarity per DIG_ACTIVE_LOW.
  - Never more than one digit enabled.
  - No enable is ever driven with stale segment data, because dig and LED7S update on the same edge.
- Registered outputs:
  - LED7S, dig and frame_done are registered.
  - They change on the edge after the tick cycle.
  - frame_done pulses on the same edge that selects digit 0.
- Reset (rst=1 at an edge), including mid-scan:
  - Prescaler, index and pending_valid are cleared.
  - active data and dp are cleared to 0; active blank is set to all ones.
  - Outputs go to their "off" values: LED7S all segments off (FF when active-low), dig all disabled, frame_done 0.
  - A load asserted together with rst is ignored.
- After reset release:
  - dig enables digit 0 on the first edge with rst=0.
  - LED7S stays off until the first committed frame, because of the blanking.
- Widths:
  - Index is clog2(DIGITS) bits, min 1.
  - Prescaler is clog2(CLK_DIV) bits.
  - No arithmetic overflow is possible beyond the defined wraps.

Decomposition:
- Package tube_pkg holds:
  - the 16-entry active-low segment table;
  - SEG_OFF (8'hFF);
  - DP_BIT (7);
  - a function hex_to_seg(nibble, dp, blank) that returns active-low segments.
- One natural sub-module, hex_to_seg7: combinational wrapper around hex_to_seg, instantiated once on the muxed nibble. Polarity inversion stays in tube_scan.

Test Plan (DIGITS=4, CLK_DIV=4, both polarities active-low unless noted):
1. Reset then idle, no load -> dig=1110 after reset, LED7S=FF throughout; dig steps 1110→1101→1011→0111 every 4 clocks; frame_done pulses once per 16 clocks.
2. load data=16'h3210, dp_in=0, blank_in=0 mid-frame -> display stays FF until the next wrap; then digits 0..3 show C0, F9, A4, B0 in order.
3. dp_in=4'b0100, blank_in=4'b1000, data=16'hFEDC -> digit0=C6, digit1=A1, digit2=86 with bit7 cleared=06, digit3=FF.
4. Two loads (16'h1111 then 16'h2222) in one frame -> only 2222 appears (A4 on all digits). A load coincident with the wrap cycle appears one frame later.
5. Assert rst for 1 cycle while digit 2 is active -> next edge: dig=1111, LED7S=FF; then digit 0 is enabled and display blank until a new load commits.
6. SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=0, data nibble 8 with dp lit -> LED7S=FF, dig one-hot high (0001 for digit 0).

Source files
------------

// File: rtl/tube_pkg.sv
// -----------------------------------------------------------------------------
// tube_pkg
// Shared definitions for the multiplexed 7-segment display driver.
//   SEG_TABLE  : active-low segment patterns for hex digits 0..F
//                (bit7 = dp, bits6..0 = g..a)
//   SEG_OFF    : active-low "all segments dark" pattern
//   DP_BIT     : bit position of the decimal point in a segment byte
//   idx_width  : width of the digit index for a given digit count (min 1)
//   hex_to_seg : nibble/dp/blank -> active-low segment byte
// -----------------------------------------------------------------------------
package tube_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam int         DP_BIT  = 7;

  // Active-low patterns, dp segment off (bit7 = 1) in every entry.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // A single digit still needs a 1-bit index so the select logic stays legal.
  function automatic int idx_width(input int digits);
    if (digits > 1) begin
      return $clog2(digits);
    end else begin
      return 1;
    end
  endfunction

  // Blanking overrides both the glyph and the decimal point.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble,
                                            input logic       dp,
                                            input logic       blank);
    logic [7:0] seg;
    if (blank) begin
      seg = SEG_OFF;
    end else begin
      seg = SEG_TABLE[nibble];
      if (dp) begin
        seg[DP_BIT] = 1'b0;
      end else begin
        seg[DP_BIT] = 1'b1;
      end
    end
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex-to-7-segment decoder producing active-low segments.
// Output polarity adaptation is left to the instantiating module.
//   nibble_i : hex value to display
//   dp_i     : 1 = light the decimal point
//   blank_i  : 1 = all segments dark
//   seg_o    : active-low segments, bit7 = dp, bits6..0 = g..a
// -----------------------------------------------------------------------------
import tube_pkg::*;

module hex_to_seg7 (
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // Pure table lookup; shared with any other user of the package function.
  always_comb begin
    seg_o = hex_to_seg(nibble_i, dp_i, blank_i);
  end

endmodule

// File: rtl/tube_scan.sv
// -----------------------------------------------------------------------------
// tube_scan
// Time-multiplexed driver for a bank of DIGITS 7-segment hex digits.
// One digit is enabled at a time for CLK_DIV clocks, round-robin. Host data
// is double-buffered: a load fills the pending buffer, which is copied to the
// active buffer only when the scan wraps back to digit 0, so a frame is never
// shown half old / half new.
//
// Ports
//   clk        : system clock
//   rst        : synchronous active-high reset
//   data       : hex nibbles, nibble i (bits 4i+3..4i) drives digit i
//   dp_in      : bit i set = decimal point of digit i lit
//   blank_in   : bit i set = digit i dark
//   load       : single-cycle strobe capturing data/dp_in/blank_in
//   LED7S      : registered segments, bit7 = dp, bits6..0 = g..a
//   dig        : registered digit enables, bit i = digit i
//   frame_done : registered one-cycle pulse on the edge that selects digit 0
// -----------------------------------------------------------------------------
import tube_pkg::*;

module tube_scan #(
  parameter int DIGITS         = 8,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  output logic [7:0]            LED7S,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);

  localparam int                IDX_W    = idx_width(DIGITS);
  localparam int                CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  // "Off" output levels depend on the board polarity.
  localparam logic [7:0]        LED_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                 : {DIGITS{1'b0}};

  // Scan state
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [IDX_W-1:0]    idx_q,        idx_d;

  // Pending (host-side) buffer
  logic [4*DIGITS-1:0] pend_data_q,  pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q,    pend_dp_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                pend_valid_q, pend_valid_d;

  // Active (display-side) buffer
  logic [4*DIGITS-1:0] act_data_q,   act_data_d;
  logic [DIGITS-1:0]   act_dp_q,     act_dp_d;
  logic [DIGITS-1:0]   act_blank_q,  act_blank_d;

  // Output registers
  logic [7:0]          led_q,        led_d;
  logic [DIGITS-1:0]   dig_q,        dig_d;
  logic                fd_q,         fd_d;

  // Decode path
  logic                tick_s;
  logic                wrap_s;
  logic [3:0]          nib_s;
  logic                dp_s;
  logic                blank_s;
  logic [7:0]          seg_s;
  logic [DIGITS-1:0]   onehot_s;

  // Prescaler and digit index: tick on the last count, wrap on tick at the last digit.
  always_comb begin
    tick_s = (cnt_q == CNT_LAST);
    wrap_s = tick_s && (idx_q == IDX_LAST);

    if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    if (wrap_s) begin
      idx_d = {IDX_W{1'b0}};
    end else if (tick_s) begin
      idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      idx_d = idx_q;
    end
  end

  // Double buffer: a wrap commits what was pending before this cycle, so a
  // load landing in the wrap cycle is kept pending for the following frame.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;

    if (wrap_s && pend_valid_q) begin
      act_data_d   = pend_data_q;
      act_dp_d     = pend_dp_q;
      act_blank_d  = pend_blank_q;
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    if (load) begin
      pend_data_d  = data;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
      pend_valid_d = 1'b1;
    end else begin
      pend_data_d  = pend_data_q;
    end
  end

  // Select the digit that will be enabled after this edge, using the active
  // buffer as it will be after this edge, so enable and segments move together.
  always_comb begin
    nib_s   = act_data_d[{idx_d, 2'b00} +: 4];
    dp_s    = act_dp_d[idx_d];
    blank_s = act_blank_d[idx_d];
    for (int i = 0; i < DIGITS; i++) begin
      onehot_s[i] = (idx_d == IDX_W'(i));
    end
  end

  hex_to_seg7 u_dec (
    .nibble_i (nib_s),
    .dp_i     (dp_s),
    .blank_i  (blank_s),
    .seg_o    (seg_s)
  );

  // Apply board polarity to the next output values.
  always_comb begin
    if (SEG_ACTIVE_LOW != 0) begin
      led_d = seg_s;
    end else begin
      led_d = ~seg_s;
    end

    if (DIG_ACTIVE_LOW != 0) begin
      dig_d = ~onehot_s;
    end else begin
      dig_d = onehot_s;
    end

    fd_d = wrap_s;
  end

  // State and output registers; reset blanks the display and drops any load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= {CNT_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      pend_data_q  <= {(4*DIGITS){1'b0}};
      pend_dp_q    <= {DIGITS{1'b0}};
      pend_blank_q <= {DIGITS{1'b0}};
      pend_valid_q <= 1'b0;
      act_data_q   <= {(4*DIGITS){1'b0}};
      act_dp_q     <= {DIGITS{1'b0}};
      act_blank_q  <= {DIGITS{1'b1}};
      led_q        <= LED_OFF;
      dig_q        <= DIG_OFF;
      fd_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      led_q        <= led_d;
      dig_q        <= dig_d;
      fd_q         <= fd_d;
    end
  end

  assign LED7S      = led_q;
  assign dig        = dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_tube_scan.sv
module tb_tube_scan;

  logic        clk;
  logic        rst;

  // Active-low instance
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic [7:0]  led;
  logic [3:0]  dig;
  logic        fd;

  // Active-high instance
  logic [15:0] data2;
  logic [3:0]  dp2;
  logic [3:0]  blank2;
  logic        load2;
  logic [7:0]  led2;
  logic [3:0]  dig2;
  logic        fd2;

  int errors = 0;
  int checks = 0;
  int k      = 0;   // edges since reset release
  int pulses;

  tube_scan #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .LED7S(led), .dig(dig), .frame_done(fd)
  );

  tube_scan #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut2 (
    .clk(clk), .rst(rst), .data(data2), .dp_in(dp2), .blank_in(blank2),
    .load(load2), .LED7S(led2), .dig(dig2), .frame_done(fd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic goto(input int t);
    if (t > k) step(t - k);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load2 = 1'b0;
    data = 16'h0000; dp_in = 4'h0; blank_in = 4'h0;
    data2 = 16'h0000; dp2 = 4'h0; blank2 = 4'h0;
    step(3);
    chk("rst_led", 16'(led), 16'h00FF);
    chk("rst_dig", 16'(dig), 16'h000F);
    chk("rst_fd",  16'(fd),  16'h0000);
    chk("rst_led2", 16'(led2), 16'h0000);
    chk("rst_dig2", 16'(dig2), 16'h0000);

    // Test 1: idle scan
    rst = 1'b0; k = 0;
    step(1);
    chk("t1_dig_k1", 16'(dig), 16'h000E);
    chk("t1_led_k1", 16'(led), 16'h00FF);
    chk("t1_dig2_k1", 16'(dig2), 16'h0001);
    chk("t1_led2_k1", 16'(led2), 16'h0000);
    goto(3);  chk("t1_dig_k3",  16'(dig), 16'h000E);
    goto(4);  chk("t1_dig_k4",  16'(dig), 16'h000D);
    goto(8);  chk("t1_dig_k8",  16'(dig), 16'h000B);
    goto(12); chk("t1_dig_k12", 16'(dig), 16'h0007);
    chk("t1_fd_k12", 16'(fd), 16'h0000);
    goto(16); chk("t1_dig_k16", 16'(dig), 16'h000E);
    chk("t1_fd_k16", 16'(fd), 16'h0001);
    chk("t1_led_k16", 16'(led), 16'h00FF);
    goto(17); chk("t1_fd_k17", 16'(fd), 16'h0000);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (fd === 1'b1) pulses++;
    end
    chk("t1_fd_count", 16'(pulses), 16'h0001);

    // Test 2: mid-frame load, committed at next wrap (k=48)
    goto(33);
    data = 16'h3210; dp_in = 4'h0; blank_in = 4'h0; load = 1'b1;
    data2 = 16'h0008; dp2 = 4'b0001; blank2 = 4'h0; load2 = 1'b1;
    step(1); load = 1'b0; load2 = 1'b0;
    chk("t2_led_k34", 16'(led), 16'h00FF);
    goto(40); chk("t2_led_k40", 16'(led), 16'h00FF);
    goto(48); chk("t2_led_d0", 16'(led), 16'h00C0);
    chk("t2_dig_d0", 16'(dig), 16'h000E);
    chk("t2_fd_k48", 16'(fd), 16'h0001);
    chk("t6_led2_d0", 16'(led2), 16'h00FF);
    chk("t6_dig2_d0", 16'(dig2), 16'h0001);
    goto(52); chk("t2_led_d1", 16'(led), 16'h00F9);
    chk("t6_led2_d1", 16'(led2), 16'h003F);
    chk("t6_dig2_d1", 16'(dig2), 16'h0002);
    goto(56); chk("t2_led_d2", 16'(led), 16'h00A4);
    goto(60); chk("t2_led_d3", 16'(led), 16'h00B0);
    chk("t2_dig_d3", 16'(dig), 16'h0007);

    // Test 3: dp and blank, committed at k=64
    data = 16'hFEDC; dp_in = 4'b0100; blank_in = 4'b1000; load = 1'b1;
    step(1); load = 1'b0;
    goto(64); chk("t3_led_d0", 16'(led), 16'h00C6);
    goto(68); chk("t3_led_d1", 16'(led), 16'h00A1);
    goto(72); chk("t3_led_d2", 16'(led), 16'h0006);
    goto(76); chk("t3_led_d3", 16'(led), 16'h00FF);
    chk("t3_dig_d3", 16'(dig), 16'h0007);

    // Test 4: last load wins; load coincident with wrap is deferred
    goto(64);
    data = 16'h1111; dp_in = 4'h0; blank_in = 4'h0; load = 1'b1;
    step(1); load = 1'b0;
    goto(69);
    data = 16'h2222; load = 1'b1;
    step(1); load = 1'b0;
    goto(80); chk("t4_led_k80", 16'(led), 16'h00A4);
    goto(84); chk("t4_led_k84", 16'(led), 16'h00A4);
    goto(89);
    data = 16'h4444; load = 1'b1;
    step(1); load = 1'b0;
    goto(95);
    data = 16'h5555; load = 1'b1;
    step(1); load = 1'b0;
    chk("t4_led_k96", 16'(led), 16'h0099);
    chk("t4_fd_k96", 16'(fd), 16'h0001);
    goto(100); chk("t4_led_k100", 16'(led), 16'h0099);
    goto(112); chk("t4_led_k112", 16'(led), 16'h0092);

    // Test 5: one-cycle reset while digit 2 active, with a load that must be ignored
    goto(121); chk("t5_dig_pre", 16'(dig), 16'h000B);
    rst = 1'b1; data = 16'h6666; load = 1'b1;
    step(1); rst = 1'b0; load = 1'b0;
    chk("t5_dig_rst", 16'(dig), 16'h000F);
    chk("t5_led_rst", 16'(led), 16'h00FF);
    chk("t5_fd_rst",  16'(fd),  16'h0000);
    chk("t5_dig2_rst", 16'(dig2), 16'h0000);
    k = 0;
    step(1);
    chk("t5_dig_k1", 16'(dig), 16'h000E);
    chk("t5_led_k1", 16'(led), 16'h00FF);
    goto(16);
    chk("t5_fd_k16", 16'(fd), 16'h0001);
    chk("t5_led_k16", 16'(led), 16'h00FF);
    chk("t5_dig_k16", 16'(dig), 16'h000E);
    chk("t5_led2_k16", 16'(led2), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
